instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 192 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: legality check plus encoding of a request, queued
// through a 4-entry in-order FIFO. Rejected requests pulse err_pulse and bump a saturating counter.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [3:0]  in_aluop,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err_pulse,
  output logic [7:0]  illegal_cnt,
  output logic [2:0]  level
);

  localparam logic [2:0] K_RALU = 3'd0;
  localparam logic [2:0] K_IALU = 3'd1;
  localparam logic [2:0] K_LW   = 3'd2;
  localparam logic [2:0] K_SW   = 3'd3;
  localparam logic [2:0] K_BEQ  = 3'd4;
  localparam logic [2:0] K_JAL  = 3'd5;
  localparam logic [2:0] K_JALR = 3'd6;
  localparam logic [2:0] K_LUI  = 3'd7;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;

  logic        alu_ok;
  logic        is_shift;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        imm12_ok;
  logic        imm13_ok;
  logic        imm21_ok;
  logic        enc_legal;
  logic [31:0] enc_word;

  always_comb begin
    alu_ok   = 1'b1;
    is_shift = 1'b0;
    funct3   = 3'b000;
    funct7   = 7'b0000000;
    case (in_aluop)
      OP_ADD: funct3 = 3'b000;
      OP_SUB: begin
        funct3 = 3'b000;
        funct7 = 7'b0100000;
      end
      OP_AND: funct3 = 3'b111;
      OP_OR:  funct3 = 3'b110;
      OP_XOR: funct3 = 3'b100;
      OP_SLL: begin
        funct3   = 3'b001;
        is_shift = 1'b1;
      end
      OP_SRL: begin
        funct3   = 3'b101;
        is_shift = 1'b1;
      end
      OP_SRA: begin
        funct3   = 3'b101;
        funct7   = 7'b0100000;
        is_shift = 1'b1;
      end
      default: alu_ok = 1'b0;
    endcase
  end

  // Sign-representability: all bits above the field's sign bit must match it.
  assign imm12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign imm13_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign imm21_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

  always_comb begin
    enc_legal = 1'b0;
    enc_word  = 32'd0;
    case (in_kind)
      K_RALU: begin
        enc_legal = alu_ok;
        enc_word  = {funct7, in_rs2, in_rs1, funct3, in_rd, OPC_R};
      end
      K_IALU: begin
        if (is_shift) begin
          enc_legal = alu_ok & ~(|in_imm[31:5]);
          enc_word  = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, OPC_I};
        end else begin
          enc_legal = alu_ok & (in_aluop != OP_SUB) & imm12_ok;
          enc_word  = {in_imm[11:0], in_rs1, funct3, in_rd, OPC_I};
        end
      end
      K_LW: begin
        enc_legal = imm12_ok;
        enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LW};
      end
      K_SW: begin
        enc_legal = imm12_ok;
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_SW};
      end
      K_BEQ: begin
        enc_legal = imm13_ok;
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                     in_imm[4:1], in_imm[11], OPC_BEQ};
      end
      K_JAL: begin
        enc_legal = imm21_ok;
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      end
      K_JALR: begin
        enc_legal = imm12_ok;
        enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
      end
      K_LUI: begin
        enc_legal = ~(|in_imm[11:0]);
        enc_word  = {in_imm[31:12], in_rd, OPC_LUI};
      end
      default: begin
        enc_legal = 1'b0;
        enc_word  = 32'd0;
      end
    endcase
  end

  logic [31:0] mem [0:3];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        accept;
  logic        push;
  logic        pop;

  assign in_ready  = (count < 3'd4);
  assign out_valid = (count != 3'd0);
  assign level     = count;
  assign accept    = in_valid & in_ready;
  assign push      = accept & enc_legal;
  assign pop       = out_valid & out_ready;
  // Empty FIFO presents zero so stale entries never leak after reset or drain.
  assign out_instr = out_valid ? mem[rd_ptr] : 32'd0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse   <= 1'b0;
      illegal_cnt <= 8'd0;
    end else begin
      err_pulse <= accept & ~enc_legal;
      if (accept && !enc_legal && illegal_cnt != 8'hFF)
        illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: directed scenarios plus random traffic,
// checked every cycle against an arithmetic encoding model and a queue scoreboard.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [3:0]  in_aluop;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err_pulse;
  logic [7:0]  illegal_cnt;
  logic [2:0]  level;

  instr_encoder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_aluop(in_aluop),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err_pulse(err_pulse), .illegal_cnt(illegal_cnt), .level(level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] mq[$];
  bit m_err;
  int m_cnt;

  localparam int unsigned P7  = 32'd128;
  localparam int unsigned P12 = 32'd4096;
  localparam int unsigned P15 = 32'd32768;
  localparam int unsigned P20 = 32'd1048576;
  localparam int unsigned P21 = 32'd2097152;
  localparam int unsigned P25 = 32'd33554432;
  localparam int unsigned P31 = 32'h8000_0000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned bits(int unsigned u, int hi, int lo);
    return (u >> lo) % (32'd1 << (hi - lo + 1));
  endfunction

  function automatic bit in_range(int s, int lo, int hi);
    return (s >= lo) && (s <= hi);
  endfunction

  function automatic bit ref_legal(int kind, int op, logic [31:0] imm);
    int s = $signed(imm);
    int unsigned u = imm;
    bit alu_ok = op inside {1, 2, 3, 4, 5, 7, 8, 9};
    bit sh = op inside {7, 8, 9};
    case (kind)
      0: return alu_ok;
      1: begin
        if (!alu_ok || op == 2) return 1'b0;
        if (sh) return u < 32;
        return in_range(s, -2048, 2047);
      end
      2, 3, 6: return in_range(s, -2048, 2047);
      4: return in_range(s, -4096, 4095) && (u % 2 == 0);
      5: return in_range(s, -1048576, 1048575) && (u % 2 == 0);
      default: return (u % 4096) == 0;
    endcase
  endfunction

  function automatic int unsigned ref_f3(int op);
    case (op)
      3: return 7;
      4: return 6;
      5: return 4;
      7: return 1;
      8, 9: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(int kind, int op, int unsigned rd, int unsigned rs1,
                                           int unsigned rs2, logic [31:0] imm);
    int unsigned u = imm;
    int unsigned f3 = ref_f3(op);
    int unsigned f7 = (op == 2 || op == 9) ? 32 : 0;
    bit sh = op inside {7, 8, 9};
    case (kind)
      0: return 51 + rd * P7 + f3 * P12 + rs1 * P15 + rs2 * P20 + f7 * P25;
      1: if (sh) return 19 + rd * P7 + f3 * P12 + rs1 * P15 + (u % 32) * P20 + f7 * P25;
         else    return 19 + rd * P7 + f3 * P12 + rs1 * P15 + (u % 4096) * P20;
      2: return 3 + rd * P7 + 2 * P12 + rs1 * P15 + (u % 4096) * P20;
      3: return 35 + (u % 32) * P7 + 2 * P12 + rs1 * P15 + rs2 * P20 + bits(u, 11, 5) * P25;
      4: return 99 + bits(u, 11, 11) * P7 + bits(u, 4, 1) * 256 + rs1 * P15 + rs2 * P20
                + bits(u, 10, 5) * P25 + bits(u, 12, 12) * P31;
      5: return 111 + rd * P7 + bits(u, 19, 12) * P12 + bits(u, 11, 11) * P20
                + bits(u, 10, 1) * P21 + bits(u, 20, 20) * P31;
      6: return 103 + rd * P7 + rs1 * P15 + (u % 4096) * P20;
      default: return (u / 4096) * 4096 + 55 + rd * P7;
    endcase
  endfunction

  // One clock cycle: drive, check state at the falling edge, advance the model.
  task automatic step(input int v, input int k, input int op, input int rd, input int rs1,
                      input int rs2, input logic [31:0] imm, input int ordy);
    bit acc, pop, lg;
    in_valid  = v[0];
    in_kind   = k[2:0];
    in_aluop  = op[3:0];
    in_rd     = rd[4:0];
    in_rs1    = rs1[4:0];
    in_rs2    = rs2[4:0];
    in_imm    = imm;
    out_ready = ordy[0];
    @(negedge clk);
    check_val("level", 32'(level), 32'(mq.size()));
    check_val("in_ready", 32'(in_ready), 32'(mq.size() < 4));
    check_val("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) check_val("out_instr", out_instr, mq[0]);
    check_val("err_pulse", 32'(err_pulse), 32'(m_err));
    check_val("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
    acc = (v != 0) && (mq.size() < 4);
    pop = (mq.size() > 0) && (ordy != 0);
    lg  = ref_legal(k, op, imm);
    if (pop) void'(mq.pop_front());
    if (acc && lg) mq.push_back(ref_word(k, op, rd, rs1, rs2, imm));
    m_err = acc && !lg;
    if (acc && !lg && m_cnt < 255) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int ordy);
    step(0, 0, 0, 0, 0, 0, 32'd0, ordy);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_level"}, 32'(level), 32'd0);
    check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_val({tag, "_out_instr"}, out_instr, 32'd0);
    check_val({tag, "_err"}, 32'(err_pulse), 32'd0);
    check_val({tag, "_cnt"}, 32'(illegal_cnt), 32'd0);
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 4))
      0: return 32'(int'($urandom_range(0, 8191)) - 4096);
      1: return 32'($urandom_range(0, 31));
      2: return $urandom;
      3: return $urandom & 32'hFFFF_F000;
      default: return 32'(int'($urandom_range(0, 2097151)) - 1048576);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_kind = 3'd0; in_aluop = 4'd0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0; out_ready = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst0");
    reset = 1'b0;

    step(1, 0, 1, 3, 1, 2, 32'd0, 0);
    check_val("r_add", out_instr, 32'h0020_81B3);
    idle(1);

    step(1, 1, 1, 1, 0, 0, 32'hFFFF_FFFF, 0);
    check_val("i_add", out_instr, 32'hFFF0_0093);
    step(1, 7, 0, 5, 0, 0, 32'h1234_5000, 1);
    check_val("lui", out_instr, 32'h1234_52B7);
    idle(1);

    step(1, 3, 0, 0, 1, 2, 32'd8, 0);
    check_val("sw", out_instr, 32'h0020_A423);
    step(1, 4, 0, 0, 1, 2, 32'd3, 1);
    check_val("beq_err", 32'(err_pulse), 32'd1);
    check_val("beq_lvl", 32'(level), 32'd0);
    idle(0);
    check_val("beq_err_end", 32'(err_pulse), 32'd0);
    check_val("beq_cnt", 32'(illegal_cnt), 32'd1);

    for (int i = 0; i < 4; i++) step(1, 2, 0, i + 4, i + 1, 0, 32'(i * 4), 0);
    check_val("full_lvl", 32'(level), 32'd4);
    check_val("full_rdy", 32'(in_ready), 32'd0);
    step(1, 6, 0, 9, 9, 0, 32'd16, 0);
    for (int i = 0; i < 4; i++) idle(1);
    check_val("drain_rdy", 32'(in_ready), 32'd1);
    check_val("drain_lvl", 32'(level), 32'd0);

    for (int i = 0; i < 256; i++) step(1, 1, 2, 1, 1, 0, 32'd5, 1);
    idle(1);
    check_val("sat_cnt", 32'(illegal_cnt), 32'd255);

    for (int i = 0; i < 3; i++) step(1, 0, 3 + i, i, i, i, 32'd0, 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_state("rst_mid");
    mq.delete();
    m_err = 1'b0;
    m_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           rand_imm(), ($urandom_range(0, 4) < 3) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
